// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor reusing one CHUNK-wide full-adder slice.
// Start/busy/done handshake; result, carry and overflow load atomically.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic [CHUNK:0]   slice;
  logic [CHUNK-1:0] s;
  logic             c_out;
  logic             c_msb;
  logic             last;
  logic [WIDTH-1:0] r_nxt;

  // On the final step the slice top bit is the MSB, so the carry into
  // it falls out of the sum bit xor the two operand bits.
  always_comb begin
    slice = (CHUNK+1)'(a_sr[CHUNK-1:0])
          + (CHUNK+1)'(b_sr[CHUNK-1:0])
          + (CHUNK+1)'(cy);
    s     = slice[CHUNK-1:0];
    c_out = slice[CHUNK];
    c_msb = s[CHUNK-1] ^ a_sr[CHUNK-1] ^ b_sr[CHUNK-1];
    r_nxt = (r_sr >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
    last  = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= A;
            b_sr  <= B ^ {WIDTH{Sub}};
            r_sr  <= '0;
            cy    <= Cin ^ Sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr <= a_sr >> CHUNK;
          b_sr <= b_sr >> CHUNK;
          r_sr <= r_nxt;
          cy   <= c_out;
          cnt  <= cnt + CW'(1);
          if (last) begin
            Sum      <= r_nxt;
            Carry    <= c_out;
            Overflow <= c_msb ^ c_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table, hand sequences and random ops
// against an integer-arithmetic reference, on CHUNK=1 and CHUNK=4 units.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st[2];
  logic       ci[2];
  logic       sb[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];
  logic       bz[2];
  logic       dn[2];
  logic       cy[2];
  logic       ov[2];
  logic [7:0] sm[2];

  serial_adder #(.WIDTH(8), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .start(st[0]), .A(av[0]), .B(bv[0]),
    .Cin(ci[0]), .Sub(sb[0]), .busy(bz[0]), .done(dn[0]),
    .Sum(sm[0]), .Carry(cy[0]), .Overflow(ov[0])
  );

  serial_adder #(.WIDTH(8), .CHUNK(4)) u4 (
    .clk(clk), .rst(rst), .start(st[1]), .A(av[1]), .B(bv[1]),
    .Cin(ci[1]), .Sub(sb[1]), .busy(bz[1]), .done(dn[1]),
    .Sum(sm[1]), .Carry(cy[1]), .Overflow(ov[1])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       s;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t tv[8];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {overflow, carry, sum} from plain integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] a, b,
                                       input logic c, s);
    logic [7:0] eb;
    logic       ec;
    int         u;
    int         v;
    eb = s ? ~b : b;
    ec = c ^ s;
    u = int'(a) + int'(eb) + int'(ec);
    v = int'($signed(a)) + int'($signed(eb)) + int'(ec);
    model = {(v > 127 || v < -128), u[8], u[7:0]};
  endfunction

  task automatic op(input int u, input logic [7:0] a, b,
                    input logic c, s, input logic [7:0] es,
                    input logic ec, eo, input string nm);
    int lat;
    int bad;
    int nexp;
    logic [7:0] held;
    nexp = (u == 0) ? 8 : 2;
    held = sm[u];
    st[u] = 1'b1;
    av[u] = a;
    bv[u] = b;
    ci[u] = c;
    sb[u] = s;
    @(posedge clk); #1;
    lat = -1;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      if (!bz[u] || dn[u] || sm[u] !== held) bad++;
      st[u] = 1'($urandom);
      av[u] = 8'($urandom);
      bv[u] = 8'($urandom);
      ci[u] = 1'($urandom);
      sb[u] = 1'($urandom);
      @(posedge clk); #1;
      if (dn[u]) begin
        lat = k;
        break;
      end
    end
    st[u] = 1'b0;
    chk({nm, "/latency"}, lat, nexp);
    chk({nm, "/busy_run"}, bad, 0);
    chk({nm, "/busy_end"}, bz[u], 0);
    chk({nm, "/sum"}, sm[u], es);
    chk({nm, "/carry"}, cy[u], ec);
    chk({nm, "/ovf"}, ov[u], eo);
    @(posedge clk); #1;
    chk({nm, "/done_pulse"}, dn[u], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int ndone;
    int prev;
    int gap_bad;
    logic [9:0] e;
    logic [7:0] ra, rb;
    logic rc, rs;

    tv[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tv[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0};
    tv[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tv[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tv[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    for (int u = 0; u < 2; u++) begin
      st[u] = 1'b0;
      ci[u] = 1'b0;
      sb[u] = 1'b0;
      av[u] = 8'h00;
      bv[u] = 8'h00;
    end

    #2;
    for (int u = 0; u < 2; u++) begin
      chk("reset/busy", bz[u], 0);
      chk("reset/done", dn[u], 0);
      chk("reset/sum", sm[u], 0);
      chk("reset/carry", cy[u], 0);
      chk("reset/ovf", ov[u], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 8; i++)
        op(u, tv[i].a, tv[i].b, tv[i].c, tv[i].s,
           tv[i].es, tv[i].ec, tv[i].eo, $sformatf("vec%0d_u%0d", i, u));

    // second start while busy must be ignored
    st[0] = 1'b1;
    av[0] = 8'h10;
    bv[0] = 8'h20;
    ci[0] = 1'b0;
    sb[0] = 1'b0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    lat = -1;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        st[0] = 1'b1;
        av[0] = 8'hFF;
        bv[0] = 8'hFF;
      end else begin
        st[0] = 1'b0;
      end
      @(posedge clk); #1;
      if (dn[0]) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
    chk("ignore/latency", lat, 8);
    chk("ignore/ndone", ndone, 1);
    chk("ignore/sum", sm[0], 8'h30);

    // async reset mid-operation
    st[0] = 1'b1;
    av[0] = 8'hAA;
    bv[0] = 8'h11;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst/busy", bz[0], 0);
    chk("arst/done", dn[0], 0);
    chk("arst/sum", sm[0], 0);
    chk("arst/carry", cy[0], 0);
    chk("arst/ovf", ov[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    op(0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "arst_recover");

    op(1, 8'h9C, 8'h64, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "chunk4");

    // start held high: done every 3 cycles on the CHUNK=4 unit
    st[1] = 1'b1;
    av[1] = 8'h9C;
    bv[1] = 8'h64;
    ci[1] = 1'b1;
    sb[1] = 1'b0;
    @(posedge clk); #1;
    prev = 0;
    gap_bad = 0;
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (dn[1]) begin
        ndone++;
        if (k - prev != (ndone == 1 ? 2 : 3)) gap_bad++;
        if (sm[1] !== 8'h01) gap_bad++;
        prev = k;
      end
    end
    st[1] = 1'b0;
    chk("b2b/ndone", ndone, 4);
    chk("b2b/spacing", gap_bad, 0);
    repeat (4) @(posedge clk);
    #1;

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 30; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        e = model(ra, rb, rc, rs);
        op(u, ra, rb, rc, rs, e[7:0], e[8], e[9],
           $sformatf("rnd%0d_u%0d", i, u));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
